// File: rtl/traffic_gen_vc.sv
// Descriptor-queue traffic source: serialises queued packets into head/body/tail flits
// and injects them into the local router port, gated by per-VC credit counters.
module traffic_gen_vc #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned PTR_W   = 10,
    parameter int unsigned DEST_W  = 14,
    parameter int unsigned NUM_VC  = 4,
    parameter int unsigned VC_W    = 2,
    parameter int unsigned LEN_W   = 10,
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fill_valid,
    input  logic [DEST_W-1:0] fill_dest,
    input  logic [VC_W-1:0]   fill_vc,
    input  logic [LEN_W-1:0]  fill_len,
    output logic              fill_ready,
    input  logic              start,
    input  logic [CNT_W-1:0]  start_total,
    output logic              flit_valid,
    output logic              flit_head,
    output logic              flit_tail,
    output logic [VC_W-1:0]   flit_vc,
    output logic [DEST_W-1:0] flit_dest,
    input  logic [NUM_VC-1:0] credit_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sent_count,
    output logic              credit_err
);

    localparam int unsigned CRD_W = $clog2(CREDITS + 1);
    localparam int unsigned ENT_W = DEST_W + VC_W + LEN_W;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    logic [ENT_W-1:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    occ_q, occ_d;
    logic [LEN_W-1:0]  flit_left_q, flit_left_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [CNT_W-1:0]  sent_count_q, sent_count_d;
    logic              done_q, done_d;
    logic              credit_err_q, credit_err_d;
    logic [CRD_W-1:0]  credit_q [NUM_VC];
    logic [CRD_W-1:0]  credit_d [NUM_VC];
    logic              flit_valid_q, flit_valid_d;
    logic              flit_head_q, flit_head_d;
    logic              flit_tail_q, flit_tail_d;
    logic [VC_W-1:0]   flit_vc_q, flit_vc_d;
    logic [DEST_W-1:0] flit_dest_q, flit_dest_d;

    logic [ENT_W-1:0]  cur;
    logic [DEST_W-1:0] cur_dest;
    logic [VC_W-1:0]   cur_vc;
    logic [LEN_W-1:0]  cur_len;
    logic [LEN_W-1:0]  len_eff;
    logic              wr_en;
    logic              emit;
    logic              is_head;
    logic              is_tail;
    logic              pop;

    assign fill_ready = (occ_q != (PTR_W + 1)'(DEPTH));
    assign wr_en      = fill_valid && fill_ready;

    assign cur      = mem_q[rd_ptr_q];
    assign cur_dest = cur[ENT_W-1 -: DEST_W];
    assign cur_vc   = cur[LEN_W +: VC_W];
    assign cur_len  = cur[LEN_W-1:0];
    // A zero-length descriptor still produces one head/tail flit.
    assign len_eff  = (cur_len == '0) ? LEN_W'(1) : cur_len;

    assign emit    = (state_q == StRun) && (occ_q != '0) && (credit_q[cur_vc] != '0);
    assign is_head = (flit_left_q == '0);
    assign is_tail = is_head ? (len_eff == LEN_W'(1)) : (flit_left_q == LEN_W'(1));
    assign pop     = emit && is_tail;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {fill_dest, fill_vc, fill_len};
        end
    end

    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        sent_count_d = sent_count_q;
        done_d       = done_q;
        credit_err_d = credit_err_q;
        flit_left_d  = flit_left_q;
        flit_valid_d = 1'b0;
        flit_head_d  = 1'b0;
        flit_tail_d  = 1'b0;
        flit_vc_d    = '0;
        flit_dest_d  = '0;

        wr_ptr_d = wr_ptr_q + (wr_en ? PTR_W'(1) : PTR_W'(0));
        rd_ptr_d = rd_ptr_q + (pop ? PTR_W'(1) : PTR_W'(0));
        occ_d    = occ_q;
        if (wr_en && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !wr_en) begin
            occ_d = occ_q - 1'b1;
        end

        if (emit) begin
            flit_valid_d = 1'b1;
            flit_head_d  = is_head;
            flit_tail_d  = is_tail;
            flit_vc_d    = cur_vc;
            flit_dest_d  = cur_dest;
            flit_left_d  = is_head ? (len_eff - LEN_W'(1)) : (flit_left_q - LEN_W'(1));
        end

        for (int v = 0; v < NUM_VC; v++) begin
            credit_d[v] = credit_q[v];
            if (credit_in[v] && !(emit && cur_vc == VC_W'(v))) begin
                if (credit_q[v] == CRD_W'(CREDITS)) begin
                    credit_err_d = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + 1'b1;
                end
            end else if (!credit_in[v] && emit && cur_vc == VC_W'(v)) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    total_d      = start_total;
                    sent_count_d = '0;
                    if (start_total == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                        done_d  = 1'b0;
                    end
                end
            end
            StRun: begin
                if (pop) begin
                    sent_count_d = sent_count_q + 1'b1;
                    if (sent_count_q + 1'b1 == total_q) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            flit_left_q  <= '0;
            total_q      <= '0;
            sent_count_q <= '0;
            done_q       <= 1'b0;
            credit_err_q <= 1'b0;
            flit_valid_q <= 1'b0;
            flit_head_q  <= 1'b0;
            flit_tail_q  <= 1'b0;
            flit_vc_q    <= '0;
            flit_dest_q  <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                credit_q[v] <= CRD_W'(CREDITS);
            end
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            flit_left_q  <= flit_left_d;
            total_q      <= total_d;
            sent_count_q <= sent_count_d;
            done_q       <= done_d;
            credit_err_q <= credit_err_d;
            flit_valid_q <= flit_valid_d;
            flit_head_q  <= flit_head_d;
            flit_tail_q  <= flit_tail_d;
            flit_vc_q    <= flit_vc_d;
            flit_dest_q  <= flit_dest_d;
            for (int v = 0; v < NUM_VC; v++) begin
                credit_q[v] <= credit_d[v];
            end
        end
    end

    assign busy       = (state_q == StRun);
    assign done       = done_q;
    assign sent_count = sent_count_q;
    assign credit_err = credit_err_q;
    assign flit_valid = flit_valid_q;
    assign flit_head  = flit_head_q;
    assign flit_tail  = flit_tail_q;
    assign flit_vc    = flit_vc_q;
    assign flit_dest  = flit_dest_q;

endmodule

// File: tb/tb_traffic_gen_vc.sv
// Directed bench for traffic_gen_vc: packet serialisation, credit stalls, queue wrap,
// streaming fills, zero-length runs, credit errors and mid-packet reset.
module tb_traffic_gen_vc;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned DEST_W = 14;
    localparam int unsigned NUM_VC = 4;
    localparam int unsigned VC_W   = 2;
    localparam int unsigned LEN_W  = 10;
    localparam int unsigned CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              fill_valid = 1'b0;
    logic [DEST_W-1:0] fill_dest = '0;
    logic [VC_W-1:0]   fill_vc = '0;
    logic [LEN_W-1:0]  fill_len = '0;
    logic              fill_ready;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  start_total = '0;
    logic              flit_valid;
    logic              flit_head;
    logic              flit_tail;
    logic [VC_W-1:0]   flit_vc;
    logic [DEST_W-1:0] flit_dest;
    logic [NUM_VC-1:0] credit_in = '0;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  sent_count;
    logic              credit_err;

    int checks = 0;
    int errors = 0;

    int exp_h[6] = '{1, 0, 0, 1, 1, 0};
    int exp_t[6] = '{0, 0, 1, 1, 0, 1};
    int exp_v[6] = '{1, 1, 1, 0, 3, 3};
    int exp_d[6] = '{5, 5, 5, 9, 2, 2};

    traffic_gen_vc dut (
        .clk        (clk),
        .rst        (rst),
        .fill_valid (fill_valid),
        .fill_dest  (fill_dest),
        .fill_vc    (fill_vc),
        .fill_len   (fill_len),
        .fill_ready (fill_ready),
        .start      (start),
        .start_total(start_total),
        .flit_valid (flit_valid),
        .flit_head  (flit_head),
        .flit_tail  (flit_tail),
        .flit_vc    (flit_vc),
        .flit_dest  (flit_dest),
        .credit_in  (credit_in),
        .busy       (busy),
        .done       (done),
        .sent_count (sent_count),
        .credit_err (credit_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fill_valid = 1'b0;
        start = 1'b0;
        credit_in = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic fill(input int dest, input int vc, input int len);
        fill_valid = 1'b1;
        fill_dest  = DEST_W'(dest);
        fill_vc    = VC_W'(vc);
        fill_len   = LEN_W'(len);
        tick();
        fill_valid = 1'b0;
    endtask

    task automatic pulse_start(input int total);
        start = 1'b1;
        start_total = CNT_W'(total);
        tick();
        start = 1'b0;
    endtask

    initial begin
        int nflits;
        int cyc;

        // Reset state
        do_reset();
        check("rst_fill_ready", 32'(fill_ready), 32'd1);
        check("rst_flit_valid", 32'(flit_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sent", 32'(sent_count), 32'd0);
        check("rst_err", 32'(credit_err), 32'd0);

        // Three packets, six back-to-back flits
        fill(5, 1, 3);
        fill(9, 0, 1);
        fill(2, 3, 2);
        pulse_start(3);
        check("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("t1_valid%0d", i), 32'(flit_valid), 32'd1);
            check($sformatf("t1_head%0d", i), 32'(flit_head), 32'(exp_h[i]));
            check($sformatf("t1_tail%0d", i), 32'(flit_tail), 32'(exp_t[i]));
            check($sformatf("t1_vc%0d", i), 32'(flit_vc), 32'(exp_v[i]));
            check($sformatf("t1_dest%0d", i), 32'(flit_dest), 32'(exp_d[i]));
        end
        tick();
        check("t1_done", 32'(done), 32'd1);
        check("t1_sent", 32'(sent_count), 32'd3);
        check("t1_idle_flit", 32'(flit_valid), 32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);

        // Credit stall on VC2
        do_reset();
        fill(7, 2, 6);
        pulse_start(1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t2_valid%0d", i), 32'(flit_valid), 32'd1);
            check($sformatf("t2_head%0d", i), 32'(flit_head), (i == 0) ? 32'd1 : 32'd0);
            check($sformatf("t2_tail%0d", i), 32'(flit_tail), 32'd0);
        end
        tick();
        check("t2_stall0", 32'(flit_valid), 32'd0);
        tick();
        check("t2_stall1", 32'(flit_valid), 32'd0);
        check("t2_stall_busy", 32'(busy), 32'd1);
        check("t2_credit0", 32'(dut.credit_q[2]), 32'd0);
        credit_in = 4'b0100;
        tick();
        check("t2_ret_noflit", 32'(flit_valid), 32'd0);
        tick();
        credit_in = 4'b0000;
        check("t2_f5_valid", 32'(flit_valid), 32'd1);
        check("t2_f5_tail", 32'(flit_tail), 32'd0);
        tick();
        check("t2_f6_valid", 32'(flit_valid), 32'd1);
        check("t2_f6_tail", 32'(flit_tail), 32'd1);
        check("t2_done", 32'(done), 32'd1);
        check("t2_sent", 32'(sent_count), 32'd1);
        check("t2_err", 32'(credit_err), 32'd0);

        // Full queue, overflow ignored, full run with pointer wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            fill(i, i % 4, 1);
        end
        check("t3_full_ready", 32'(fill_ready), 32'd0);
        check("t3_full_occ", 32'(dut.occ_q), 32'(DEPTH));
        fill(1, 1, 1);
        check("t3_ovf_occ", 32'(dut.occ_q), 32'(DEPTH));
        check("t3_ovf_wrptr", 32'(dut.wr_ptr_q), 32'd0);
        pulse_start(DEPTH);
        nflits = 0;
        cyc = 0;
        while (!done && cyc < 1200) begin
            tick();
            cyc++;
            if (flit_valid) begin
                nflits++;
                credit_in = NUM_VC'(1) << flit_vc;
            end else begin
                credit_in = '0;
            end
        end
        check("t3_timeout", 32'(done), 32'd1);
        tick();
        credit_in = '0;
        check("t3_flits", 32'(nflits), 32'(DEPTH));
        check("t3_sent", 32'(sent_count), 32'(DEPTH));
        check("t3_rdptr", 32'(dut.rd_ptr_q), 32'd0);
        check("t3_wrptr", 32'(dut.wr_ptr_q), 32'd0);
        check("t3_occ", 32'(dut.occ_q), 32'd0);
        check("t3_ready", 32'(fill_ready), 32'd1);
        check("t3_err", 32'(credit_err), 32'd0);

        // Streaming: start on empty queue, fill mid-run
        do_reset();
        pulse_start(2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t4_empty%0d", i), 32'(flit_valid), 32'd0);
        end
        check("t4_busy", 32'(busy), 32'd1);
        fill(3, 1, 1);
        check("t4_wr_noflit", 32'(flit_valid), 32'd0);
        tick();
        check("t4_f1_valid", 32'(flit_valid), 32'd1);
        check("t4_f1_ht", 32'({flit_head, flit_tail}), 32'd3);
        check("t4_f1_dest", 32'(flit_dest), 32'd3);
        check("t4_f1_done", 32'(done), 32'd0);
        check("t4_f1_sent", 32'(sent_count), 32'd1);
        tick();
        check("t4_wait_done", 32'(done), 32'd0);
        fill(4, 0, 2);
        tick();
        check("t4_f2_head", 32'({flit_valid, flit_head, flit_tail}), 32'd6);
        check("t4_f2_done", 32'(done), 32'd0);
        tick();
        check("t4_f3_tail", 32'({flit_valid, flit_head, flit_tail}), 32'd5);
        check("t4_f3_dest", 32'(flit_dest), 32'd4);
        check("t4_done", 32'(done), 32'd1);
        check("t4_sent", 32'(sent_count), 32'd2);

        // Zero-length run and credit overflow error
        do_reset();
        pulse_start(0);
        check("t5_done", 32'(done), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        tick();
        check("t5_noflit", 32'(flit_valid), 32'd0);
        check("t5_done_hold", 32'(done), 32'd1);
        check("t5_err_pre", 32'(credit_err), 32'd0);
        credit_in = 4'b0001;
        tick();
        credit_in = 4'b0000;
        check("t5_err_set", 32'(credit_err), 32'd1);
        check("t5_credit_hold", 32'(dut.credit_q[0]), 32'd4);
        tick();
        tick();
        check("t5_err_sticky", 32'(credit_err), 32'd1);
        do_reset();
        check("t5_err_clr", 32'(credit_err), 32'd0);
        check("t5_done_clr", 32'(done), 32'd0);

        // Reset mid-packet
        fill(11, 0, 4);
        pulse_start(1);
        tick();
        check("t6_f1_head", 32'({flit_valid, flit_head}), 32'd3);
        tick();
        check("t6_f2_body", 32'({flit_valid, flit_head, flit_tail}), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_valid", 32'(flit_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_sent", 32'(sent_count), 32'd0);
        check("t6_ready", 32'(fill_ready), 32'd1);
        check("t6_credit", 32'(dut.credit_q[0]), 32'd4);
        check("t6_occ", 32'(dut.occ_q), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6_notail%0d", i), 32'(flit_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
